inst_encoder: RTL and testbench

Instruction-word encoder: the reverse of the datapath's ALU decode. Accepts an operation request (format, `ALU_*` code from ALUop.vh, register fields, immediate) over a valid/ready handshake and emits legal Antares-R2 MIPS instruction words with sequential word addresses for loading instruction memory. It is used by the boot loader and self-test sequencer. It expands the 32-bit load-immediate pseudo-op (LI) into LUI+ORI.

---
 rtl/inst_encoder.sv | 240 ++++++++++++++++++++++++
 tb/tb_inst_encoder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// Instruction-word encoder: turns ALU-level operation requests into Antares-R2 MIPS words
// with sequential word addresses; LI is expanded into LUI+ORI when the upper half is non-zero.
module inst_encoder #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_fmt,
    input  logic [3:0]        req_aluop,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    // ALU operation codes (ALUop.vh encoding)
    localparam logic [3:0] ALU_ADDU = 4'd0;
    localparam logic [3:0] ALU_SUBU = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_FULL      = 2'd1,
        ST_FULL_PEND = 2'd2
    } state_t;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, sh, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm16);
        return {opc, rs, rt, imm16};
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [31:0]       out_inst_r;
    logic [31:0]       pend_inst_r;
    logic [ADDR_W-1:0] out_addr_r;
    logic              out_valid_r;
    logic              err_r;

    logic              legal_s;
    logic              two_s;
    logic [5:0]        funct_s;
    logic [5:0]        opc_s;
    logic [31:0]       word0_s;
    logic [31:0]       word1_s;
    logic              req_ready_s;
    logic              req_fire_s;
    logic              out_fire_s;
    logic              load_new_s;
    logic              load_pend_s;

    // Encode the current request into one or two words and flag illegal combinations
    always_comb begin
        legal_s = 1'b0;
        two_s   = 1'b0;
        funct_s = 6'h00;
        opc_s   = 6'h00;
        word0_s = 32'h0000_0000;
        word1_s = 32'h0000_0000;
        case (req_fmt)
            2'd0: begin
                legal_s = 1'b1;
                case (req_aluop)
                    ALU_SLL:  funct_s = F_SLLV;
                    ALU_SRL:  funct_s = F_SRLV;
                    ALU_SRA:  funct_s = F_SRAV;
                    ALU_ADDU: funct_s = F_ADDU;
                    ALU_SUBU: funct_s = F_SUBU;
                    ALU_AND:  funct_s = F_AND;
                    ALU_OR:   funct_s = F_OR;
                    ALU_XOR:  funct_s = F_XOR;
                    ALU_NOR:  funct_s = F_NOR;
                    ALU_SLT:  funct_s = F_SLT;
                    ALU_SLTU: funct_s = F_SLTU;
                    default:  legal_s = 1'b0;
                endcase
                word0_s = r_word(req_rs, req_rt, req_rd, 5'd0, funct_s);
            end
            2'd1: begin
                legal_s = 1'b1;
                case (req_aluop)
                    ALU_SLL: funct_s = F_SLL;
                    ALU_SRL: funct_s = F_SRL;
                    ALU_SRA: funct_s = F_SRA;
                    default: legal_s = 1'b0;
                endcase
                word0_s = r_word(5'd0, req_rt, req_rd, req_shamt, funct_s);
            end
            2'd2: begin
                legal_s = 1'b1;
                case (req_aluop)
                    ALU_ADDU: opc_s = OP_ADDIU;
                    ALU_SLT:  opc_s = OP_SLTI;
                    ALU_SLTU: opc_s = OP_SLTIU;
                    ALU_AND:  opc_s = OP_ANDI;
                    ALU_OR:   opc_s = OP_ORI;
                    ALU_XOR:  opc_s = OP_XORI;
                    ALU_LUI:  opc_s = OP_LUI;
                    default:  legal_s = 1'b0;
                endcase
                word0_s = i_word(opc_s, (req_aluop == ALU_LUI) ? 5'd0 : req_rs,
                                 req_rt, req_imm[15:0]);
            end
            2'd3: begin
                legal_s = 1'b1;
                if (req_imm[31:16] == 16'h0000) begin
                    word0_s = i_word(OP_ORI, 5'd0, req_rt, req_imm[15:0]);
                end else begin
                    // ORI must read rt back so the LUI result is preserved
                    two_s   = 1'b1;
                    word0_s = i_word(OP_LUI, 5'd0, req_rt, req_imm[31:16]);
                    word1_s = i_word(OP_ORI, req_rt, req_rt, req_imm[15:0]);
                end
            end
            default: legal_s = 1'b0;
        endcase
    end

    assign req_ready_s = (state_r == ST_EMPTY) || ((state_r == ST_FULL) && out_ready);
    assign req_fire_s  = req_valid && req_ready_s;
    assign out_fire_s  = out_valid_r && out_ready;

    // Next-state and register-load decisions for the output holding register
    always_comb begin
        state_nxt_s = state_r;
        load_new_s  = 1'b0;
        load_pend_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (req_fire_s && legal_s) begin
                    load_new_s  = 1'b1;
                    state_nxt_s = two_s ? ST_FULL_PEND : ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire_s) begin
                    if (req_fire_s && legal_s) begin
                        load_new_s  = 1'b1;
                        state_nxt_s = two_s ? ST_FULL_PEND : ST_FULL;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            ST_FULL_PEND: begin
                if (out_fire_s) begin
                    load_pend_s = 1'b1;
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_FULL_PEND;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // State, output word, address counter and error pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            out_valid_r <= 1'b0;
            out_inst_r  <= 32'h0000_0000;
            pend_inst_r <= 32'h0000_0000;
            out_addr_r  <= BASE_ADDR;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            out_valid_r <= (state_nxt_s != ST_EMPTY);
            err_r       <= req_fire_s && !legal_s;
            if (out_fire_s) begin
                out_addr_r <= out_addr_r + ADDR_W'(3'd4);
            end
            if (load_new_s) begin
                out_inst_r  <= word0_s;
                pend_inst_r <= word1_s;
            end else if (load_pend_s) begin
                out_inst_r <= pend_inst_r;
            end
        end
    end

    assign req_ready = req_ready_s;
    assign out_valid = out_valid_r;
    assign out_inst  = out_inst_r;
    assign out_addr  = out_addr_r;
    assign err       = err_r;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios plus a randomized run scored
// against a queue-based reference model of the emitted instruction stream.
module tb_inst_encoder;

    localparam logic [3:0] ALU_ADDU = 4'd0,  ALU_SUBU = 4'd1,  ALU_AND = 4'd2,  ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4,  ALU_NOR  = 4'd5,  ALU_SLT = 4'd6,  ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8,  ALU_SRL  = 4'd9,  ALU_SRA = 4'd10, ALU_LUI = 4'd11;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_ready, out_valid, out_ready, err;
    logic [1:0]  req_fmt;
    logic [3:0]  req_aluop;
    logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
    logic [31:0] req_imm, out_inst, out_addr;

    logic        w_reset, w_req_valid, w_req_ready, w_out_valid, w_out_ready, w_err;
    logic [1:0]  w_req_fmt;
    logic [3:0]  w_req_aluop;
    logic [4:0]  w_req_rs, w_req_rt, w_req_rd, w_req_shamt;
    logic [31:0] w_req_imm, w_out_inst;
    logic [3:0]  w_out_addr;

    int vectors = 0;
    int miscompares = 0;
    int rr_funct[16];
    int sh_funct[16];
    int i_opc[16];

    always #5 clk = ~clk;

    inst_encoder #(.ADDR_W(32), .BASE_ADDR(32'd0)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt(req_fmt), .req_aluop(req_aluop), .req_rs(req_rs), .req_rt(req_rt),
        .req_rd(req_rd), .req_shamt(req_shamt), .req_imm(req_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_addr(out_addr), .err(err)
    );

    inst_encoder #(.ADDR_W(4), .BASE_ADDR(4'd12)) dut_w (
        .clk(clk), .reset(w_reset), .req_valid(w_req_valid), .req_ready(w_req_ready),
        .req_fmt(w_req_fmt), .req_aluop(w_req_aluop), .req_rs(w_req_rs), .req_rt(w_req_rt),
        .req_rd(w_req_rd), .req_shamt(w_req_shamt), .req_imm(w_req_imm),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_inst(w_out_inst),
        .out_addr(w_out_addr), .err(w_err)
    );

    // Reference encoder: MIPS field arithmetic driven by lookup tables (-1 = illegal)
    function automatic void model(input logic [1:0] fmt, input logic [3:0] op,
                                  input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [4:0] rd, input logic [4:0] sh,
                                  input logic [31:0] imm, output bit legal, output int n,
                                  output logic [31:0] w0, output logic [31:0] w1);
        int code;
        legal = 1'b0; n = 0; w0 = 32'd0; w1 = 32'd0;
        case (fmt)
            2'd0: begin
                code = rr_funct[op];
                if (code >= 0) begin
                    legal = 1'b1; n = 1;
                    w0 = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(code);
                end
            end
            2'd1: begin
                code = sh_funct[op];
                if (code >= 0) begin
                    legal = 1'b1; n = 1;
                    w0 = (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(code);
                end
            end
            2'd2: begin
                code = i_opc[op];
                if (code >= 0) begin
                    legal = 1'b1; n = 1;
                    w0 = (32'(code) << 26) | ((op == ALU_LUI) ? 32'd0 : (32'(rs) << 21))
                         | (32'(rt) << 16) | (imm & 32'h0000_FFFF);
                end
            end
            default: begin
                legal = 1'b1;
                if ((imm >> 16) == 32'd0) begin
                    n = 1;
                    w0 = (32'd13 << 26) | (32'(rt) << 16) | imm;
                end else begin
                    n = 2;
                    w0 = (32'd15 << 26) | (32'(rt) << 16) | (imm >> 16);
                    w1 = (32'd13 << 26) | (32'(rt) << 21) | (32'(rt) << 16) | (imm & 32'h0000_FFFF);
                end
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] fmt, input logic [3:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                         input logic [31:0] imm);
        int waited = 0;
        req_valid = 1'b1; req_fmt = fmt; req_aluop = op; req_rs = rs; req_rt = rt;
        req_rd = rd; req_shamt = sh; req_imm = imm;
        #1;
        while (!req_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!req_ready) begin
            vectors++; miscompares++;
            $display("FAIL issue_timeout: req_ready still %b after %0d cycles, want 1", req_ready, waited);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; out_ready = 1'b0; req_fmt = 2'd0; req_aluop = 4'd0;
        req_rs = 5'd0; req_rt = 5'd0; req_rd = 5'd0; req_shamt = 5'd0; req_imm = 32'd0;
        tick(); tick();
        reset = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        vectors++; if (out_inst !== 32'd0) begin miscompares++; $display("FAIL reset_inst: got %h want 0", out_inst); end
        vectors++; if (out_addr !== 32'd0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", out_addr); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_encodings();
        out_ready = 1'b1;
        issue(2'd0, ALU_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL addu_valid: got %b want 1", out_valid); end
        vectors++; if (out_inst !== 32'h0022_1821) begin miscompares++; $display("FAIL addu_inst: got %h want 00221821", out_inst); end
        vectors++; if (out_addr !== 32'd0) begin miscompares++; $display("FAIL addu_addr: got %h want 0", out_addr); end
        issue(2'd3, 4'hF, 5'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
        vectors++; if (out_inst !== 32'h3C05_1234) begin miscompares++; $display("FAIL li_lui_inst: got %h want 3c051234", out_inst); end
        vectors++; if (out_addr !== 32'd4) begin miscompares++; $display("FAIL li_lui_addr: got %h want 4", out_addr); end
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL li_lui_ready: got %b want 0", req_ready); end
        tick();
        vectors++; if (out_inst !== 32'h34A5_5678) begin miscompares++; $display("FAIL li_ori_inst: got %h want 34a55678", out_inst); end
        vectors++; if (out_addr !== 32'd8) begin miscompares++; $display("FAIL li_ori_addr: got %h want 8", out_addr); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL li_ori_ready: got %b want 1", req_ready); end
        issue(2'd3, 4'd0, 5'd0, 5'd5, 5'd0, 5'd0, 32'h0000_5678);
        vectors++; if (out_inst !== 32'h3405_5678) begin miscompares++; $display("FAIL li_short_inst: got %h want 34055678", out_inst); end
        issue(2'd2, ALU_ADDU, 5'd0, 5'd4, 5'd0, 5'd0, 32'h0000_FFFF);
        vectors++; if (out_inst !== 32'h2404_FFFF) begin miscompares++; $display("FAIL addiu_inst: got %h want 2404ffff", out_inst); end
        vectors++; if (out_addr !== 32'd16) begin miscompares++; $display("FAIL addiu_addr: got %h want 16", out_addr); end
        issue(2'd1, ALU_SLL, 5'd7, 5'd1, 5'd2, 5'd4, 32'd0);
        vectors++; if (out_inst !== 32'h0001_1100) begin miscompares++; $display("FAIL sll_inst: got %h want 00011100", out_inst); end
        vectors++; if (out_addr !== 32'd20) begin miscompares++; $display("FAIL sll_addr: got %h want 20", out_addr); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        issue(2'd2, ALU_NOR, 5'd1, 5'd2, 5'd0, 5'd0, 32'h0000_0001);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL ill_err: got %b want 1", err); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ill_valid: got %b want 0", out_valid); end
        tick();
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL ill_err_pulse: got %b want 0", err); end
        issue(2'd0, ALU_ADDU, 5'd1, 5'd2, 5'd9, 5'd0, 32'd0);
        vectors++; if (out_addr !== 32'd24) begin miscompares++; $display("FAIL ill_next_addr: got %h want 24", out_addr); end
        issue(2'd0, 4'd13, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL ill_full_err: got %b want 1", err); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ill_full_valid: got %b want 0", out_valid); end
        issue(2'd1, ALU_ADDU, 5'd0, 5'd1, 5'd1, 5'd3, 32'd0);
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL ill_fmt1_err: got %b want 1", err); end
        issue(2'd0, ALU_OR, 5'd3, 5'd4, 5'd5, 5'd0, 32'd0);
        vectors++; if (out_addr !== 32'd28) begin miscompares++; $display("FAIL ill_after_addr: got %h want 28", out_addr); end
        vectors++; if (out_inst !== 32'h0064_2825) begin miscompares++; $display("FAIL or_inst: got %h want 00642825", out_inst); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[4];
        logic [31:0] d1;
        bit          lg;
        int          n;
        for (int k = 0; k < 4; k++) model(2'd0, ALU_SUBU, 5'd6, 5'd7, 5'(10 + k), 5'd0, 32'd0, lg, n, w[k], d1);
        out_ready = 1'b0;
        issue(2'd0, ALU_SUBU, 5'd6, 5'd7, 5'd10, 5'd0, 32'd0);
        req_valid = 1'b1; req_rd = 5'd11;
        for (int c = 0; c < 5; c++) begin
            vectors++; if (out_inst !== w[0] || out_addr !== 32'd32 || out_valid !== 1'b1)
                begin miscompares++; $display("FAIL hold_c%0d: got %h@%h v%b want %h@20 v1", c, out_inst, out_addr, out_valid, w[0]); end
            vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL hold_ready_c%0d: got %b want 0", c, req_ready); end
            tick();
        end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            req_rd = 5'(10 + k);
            #1;
            vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_%0d: got %b want 1", k, req_ready); end
            vectors++; if (out_inst !== w[k-1] || out_addr !== 32'(32 + 4 * (k - 1)))
                begin miscompares++; $display("FAIL b2b_word_%0d: got %h@%h want %h@%h", k - 1, out_inst, out_addr, w[k-1], 32 + 4 * (k - 1)); end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        vectors++; if (out_inst !== w[3] || out_addr !== 32'd44)
            begin miscompares++; $display("FAIL b2b_word_3: got %h@%h want %h@2c", out_inst, out_addr, w[3]); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_wrap();
        w_reset = 1'b1; w_req_valid = 1'b0; w_out_ready = 1'b1; w_req_fmt = 2'd3; w_req_aluop = 4'd0;
        w_req_rs = 5'd0; w_req_rt = 5'd5; w_req_rd = 5'd0; w_req_shamt = 5'd0; w_req_imm = 32'h1234_5678;
        tick(); tick();
        w_reset = 1'b0;
        vectors++; if (w_out_addr !== 4'd12) begin miscompares++; $display("FAIL wrap_reset_addr: got %0d want 12", w_out_addr); end
        w_req_valid = 1'b1;
        tick();
        w_req_valid = 1'b0;
        vectors++; if (w_out_inst !== 32'h3C05_1234 || w_out_addr !== 4'd12)
            begin miscompares++; $display("FAIL wrap_w0: got %h@%0d want 3c051234@12", w_out_inst, w_out_addr); end
        tick();
        vectors++; if (w_out_inst !== 32'h34A5_5678 || w_out_addr !== 4'd0)
            begin miscompares++; $display("FAIL wrap_w1: got %h@%0d want 34a55678@0", w_out_inst, w_out_addr); end
        tick();
        w_out_ready = 1'b0; w_req_valid = 1'b1;
        tick();
        w_req_valid = 1'b0;
        vectors++; if (w_out_valid !== 1'b1 || w_req_ready !== 1'b0)
            begin miscompares++; $display("FAIL wrap_pend: got v%b r%b want v1 r0", w_out_valid, w_req_ready); end
        w_reset = 1'b1;
        tick();
        w_reset = 1'b0; w_out_ready = 1'b1;
        vectors++; if (w_out_valid !== 1'b0 || w_out_addr !== 4'd12)
            begin miscompares++; $display("FAIL wrap_midreset: got v%b @%0d want v0 @12", w_out_valid, w_out_addr); end
        tick();
        vectors++; if (w_out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_no_ori: got %b want 0", w_out_valid); end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] exp_addr = 32'd0;
        logic [31:0] w0, w1;
        bit          exp_err = 1'b0;
        bit          exp_ready, lg;
        int          n;
        reset = 1'b1; req_valid = 1'b0;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 600; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_fmt = 2'($urandom_range(0, 3)); req_aluop = 4'($urandom_range(0, 15));
            req_rs = 5'($urandom); req_rt = 5'($urandom); req_rd = 5'($urandom); req_shamt = 5'($urandom);
            req_imm = ($urandom_range(0, 1) != 0) ? $urandom : {16'h0000, 16'($urandom)};
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = (q.size() == 0) || (q.size() == 1 && out_ready);
            vectors++; if (req_ready !== exp_ready) begin miscompares++; $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready, exp_ready); end
            if (q.size() != 0) begin
                vectors++; if (out_inst !== q[0] || out_addr !== exp_addr)
                    begin miscompares++; $display("FAIL rnd_word c%0d: got %h@%h want %h@%h", c, out_inst, out_addr, q[0], exp_addr); end
                if (out_ready) begin
                    void'(q.pop_front());
                    exp_addr = exp_addr + 32'd4;
                end
            end
            exp_err = 1'b0;
            if (req_valid && exp_ready) begin
                model(req_fmt, req_aluop, req_rs, req_rt, req_rd, req_shamt, req_imm, lg, n, w0, w1);
                if (lg) begin
                    q.push_back(w0);
                    if (n == 2) q.push_back(w1);
                end
                exp_err = !lg;
            end
            @(posedge clk);
            #1;
            vectors++; if (out_valid !== (q.size() != 0)) begin miscompares++; $display("FAIL rnd_valid c%0d: got %b want %b", c, out_valid, q.size() != 0); end
            vectors++; if (err !== exp_err) begin miscompares++; $display("FAIL rnd_err c%0d: got %b want %b", c, err, exp_err); end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin rr_funct[i] = -1; sh_funct[i] = -1; i_opc[i] = -1; end
        rr_funct[ALU_ADDU] = 'h21; rr_funct[ALU_SUBU] = 'h23; rr_funct[ALU_AND] = 'h24;
        rr_funct[ALU_OR] = 'h25; rr_funct[ALU_XOR] = 'h26; rr_funct[ALU_NOR] = 'h27;
        rr_funct[ALU_SLT] = 'h2A; rr_funct[ALU_SLTU] = 'h2B;
        rr_funct[ALU_SLL] = 'h04; rr_funct[ALU_SRL] = 'h06; rr_funct[ALU_SRA] = 'h07;
        sh_funct[ALU_SLL] = 'h00; sh_funct[ALU_SRL] = 'h02; sh_funct[ALU_SRA] = 'h03;
        i_opc[ALU_ADDU] = 'h09; i_opc[ALU_SLT] = 'h0A; i_opc[ALU_SLTU] = 'h0B; i_opc[ALU_AND] = 'h0C;
        i_opc[ALU_OR] = 'h0D; i_opc[ALU_XOR] = 'h0E; i_opc[ALU_LUI] = 'h0F;
        w_reset = 1'b1; w_req_valid = 1'b0; w_out_ready = 1'b0; w_req_fmt = 2'd0; w_req_aluop = 4'd0;
        w_req_rs = 5'd0; w_req_rt = 5'd0; w_req_rd = 5'd0; w_req_shamt = 5'd0; w_req_imm = 32'd0;
        test_reset();
        test_encodings();
        test_illegal();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
